fetch_pc_gen: RTL

Fetch-address generator that sits upstream of the IFU fetch-request queue and drives its enqueue side. Each cycle it offers one fetch request with a valid/ready handshake. A request is a start PC inside a 16-byte fetch block, a cut position (instruction count) and a branch prediction. Prediction comes from a small direct-mapped block BTB trained by the backend. Backend redirects restart the stream at a new PC.

---
 rtl/fetch_pc_gen.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fetch_pc_gen.sv
// Fetch-address generator: offers one fetch request per cycle to the IFU queue,
// cutting each 16-byte block at a BTB-predicted taken branch; backend redirects restart the stream.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC    = 32'h1C00_0000,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        btb_upd_valid,
    input  logic [31:0] btb_upd_pc,
    input  logic        btb_upd_taken,
    input  logic [31:0] btb_upd_target,
    input  logic        ifu_ready,
    output logic        out_valid,
    output logic [31:0] fetch_pc,
    output logic [1:0]  cut_pos,
    output logic        pred_taken,
    output logic [31:0] pred_jump_target_pc
);

    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 28 - IDX;

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
    logic [1:0]             btb_slot_q   [BTB_ENTRIES];
    logic [31:0]            btb_target_q [BTB_ENTRIES];
    logic [1:0]             btb_ctr_q    [BTB_ENTRIES];

    logic [IDX-1:0] rd_idx;
    logic [1:0]     rd_off;
    logic [1:0]     rd_slot;
    logic           rd_hit;
    logic [31:0]    next_pc;

    logic [IDX-1:0]   upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic [1:0]       upd_slot;
    logic             upd_tag_hit;
    logic [1:0]       upd_ctr_old;
    logic             btb_we;
    logic [TAG_W-1:0] btb_tag_d;
    logic [1:0]       btb_slot_d;
    logic [31:0]      btb_target_d;
    logic [1:0]       btb_ctr_d;

    // Branch slots are word-granular; the byte offset of the update PC carries no information.
    logic unused_upd_bits;
    assign unused_upd_bits = ^btb_upd_pc[1:0];

    // Lookup sees the BTB contents from before this cycle's update.
    always_comb begin
        rd_idx     = pc_q[IDX+3:4];
        rd_off     = pc_q[3:2];
        rd_slot    = btb_slot_q[rd_idx];
        rd_hit     = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == pc_q[31:IDX+4])
                     && (rd_slot >= rd_off);
        pred_taken = rd_hit && btb_ctr_q[rd_idx][1];
        fetch_pc   = pc_q;
        if (pred_taken) begin
            cut_pos             = rd_slot - rd_off + 2'd1;
            next_pc             = btb_target_q[rd_idx];
            pred_jump_target_pc = btb_target_q[rd_idx];
        end else begin
            cut_pos             = 2'd0 - rd_off;
            next_pc             = {pc_q[31:4], 4'b0000} + 32'd16;
            pred_jump_target_pc = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN:  out_valid = !stall && !redirect_valid;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (out_valid && ifu_ready) begin
            pc_d = next_pc;
        end
    end

    // Default write data is a fresh allocation; a same-slot hit only trains ctr/target.
    always_comb begin
        upd_idx      = btb_upd_pc[IDX+3:4];
        upd_tag      = btb_upd_pc[31:IDX+4];
        upd_slot     = btb_upd_pc[3:2];
        upd_ctr_old  = btb_ctr_q[upd_idx];
        upd_tag_hit  = btb_valid_q[upd_idx] && (btb_tag_q[upd_idx] == upd_tag);
        btb_we       = 1'b0;
        btb_tag_d    = upd_tag;
        btb_slot_d   = upd_slot;
        btb_target_d = btb_upd_target;
        btb_ctr_d    = 2'b10;
        if (btb_upd_valid) begin
            if (upd_tag_hit && (btb_slot_q[upd_idx] == upd_slot)) begin
                btb_we = 1'b1;
                if (btb_upd_taken) begin
                    btb_ctr_d = (upd_ctr_old == 2'b11) ? upd_ctr_old : upd_ctr_old + 2'd1;
                end else begin
                    btb_ctr_d    = (upd_ctr_old == 2'b00) ? upd_ctr_old : upd_ctr_old - 2'd1;
                    btb_target_d = btb_target_q[upd_idx];
                end
            end else if (btb_upd_taken) begin
                btb_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            btb_valid_q <= '0;
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag_q[i]    <= '0;
                btb_slot_q[i]   <= '0;
                btb_target_q[i] <= '0;
                btb_ctr_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (btb_we) begin
                btb_valid_q[upd_idx]  <= 1'b1;
                btb_tag_q[upd_idx]    <= btb_tag_d;
                btb_slot_q[upd_idx]   <= btb_slot_d;
                btb_target_q[upd_idx] <= btb_target_d;
                btb_ctr_q[upd_idx]    <= btb_ctr_d;
            end
        end
    end

endmodule
